// File: rtl/clock_frame_writer_if.sv
// Pixel-stream and image-memory write bundle for clock_frame_writer.
// master = stream source / memory side (testbench), slave = the writer itself.
interface clock_frame_writer_if #(
   parameter int DATASIZE    = 24,
   parameter int IM_ADDRSIZE = 16
);
   logic                   frame_arm;
   logic [7:0]             org_x;
   logic [7:0]             org_y;
   logic                   pix_valid;
   logic [DATASIZE-1:0]    pix_data;
   logic                   im_ready;
   logic [IM_ADDRSIZE-1:0] IM_A;
   logic [DATASIZE-1:0]    IM_D;
   logic                   IM_WEN;
   logic                   busy;
   logic                   done;
   logic                   overflow;

   modport master (
      output frame_arm, org_x, org_y, pix_valid, pix_data, im_ready,
      input  IM_A, IM_D, IM_WEN, busy, done, overflow
   );

   modport slave (
      input  frame_arm, org_x, org_y, pix_valid, pix_data, im_ready,
      output IM_A, IM_D, IM_WEN, busy, done, overflow
   );
endinterface

// File: rtl/clock_frame_writer.sv
// Writes the 8-character clock pixel stream into image memory through a small
// write FIFO; one done pulse per completed frame, sticky overflow on dropped pixels.
module clock_frame_writer #(
   parameter int DATASIZE    = 24,
   parameter int IM_ADDRSIZE = 16,
   parameter int IMG_W       = 256,
   parameter int CHAR_W      = 13,
   parameter int CHAR_H      = 24,
   parameter int CHAR_NUM    = 8,
   parameter int FIFO_DEPTH  = 4
) (
   input logic                  clk,
   input logic                  reset,
   clock_frame_writer_if.slave  bus
);
   localparam int COL_W   = $clog2(CHAR_W);
   localparam int ROW_W   = $clog2(CHAR_H);
   localparam int CHR_W   = $clog2(CHAR_NUM);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = IM_ADDRSIZE + DATASIZE;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARMED = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]             state_q,    state_d;
   logic [COL_W-1:0]       col_q,      col_d;
   logic [ROW_W-1:0]       row_q,      row_d;
   logic [CHR_W-1:0]       chr_q,      chr_d;
   logic [7:0]             org_x_q,    org_x_d;
   logic [7:0]             org_y_q,    org_y_d;
   logic [PTR_W:0]         wr_ptr_q,   wr_ptr_d;
   logic [PTR_W:0]         rd_ptr_q,   rd_ptr_d;
   logic [IM_ADDRSIZE-1:0] im_a_q,     im_a_d;
   logic [DATASIZE-1:0]    im_d_q,     im_d_d;
   logic                   im_wen_q,   im_wen_d;
   logic                   overflow_q, overflow_d;

   logic [ENTRY_W-1:0]     fifo_mem [FIFO_DEPTH];

   logic                   accept, last_pix, fifo_empty, fifo_full, pop, push;
   logic [IM_ADDRSIZE-1:0] pix_addr;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign accept   = bus.pix_valid && ((state_q == S_ARMED) || (state_q == S_RUN));
   assign last_pix = (col_q == COL_W'(CHAR_W - 1)) && (row_q == ROW_W'(CHAR_H - 1)) &&
                     (chr_q == CHR_W'(CHAR_NUM - 1));
   assign pop      = !fifo_empty && bus.im_ready;
   assign push     = accept && (!fifo_full || pop);

   assign pix_addr = IM_ADDRSIZE'((32'(org_y_q) + 32'(row_q)) * 32'(IMG_W) + 32'(org_x_q) +
                                  32'(chr_q) * 32'(CHAR_W) + 32'(col_q));

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      chr_d      = chr_q;
      org_x_d    = org_x_q;
      org_y_d    = org_y_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      im_a_d     = im_a_q;
      im_d_d     = im_d_q;
      im_wen_d   = 1'b0;
      overflow_d = overflow_q;

      if (accept) begin
         if (col_q == COL_W'(CHAR_W - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(CHAR_H - 1)) begin
               row_d = '0;
               chr_d = (chr_q == CHR_W'(CHAR_NUM - 1)) ? '0 : chr_q + 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
         if (fifo_full && !pop) overflow_d = 1'b1;
      end

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
         rd_ptr_d           = rd_ptr_q + 1'b1;
         im_wen_d           = 1'b1;
         {im_a_d, im_d_d}   = fifo_mem[rd_ptr_q[PTR_W-1:0]];
      end

      case (state_q)
         S_IDLE: begin
            if (bus.frame_arm) begin
               state_d = S_ARMED;
               org_x_d = bus.org_x;
               org_y_d = bus.org_y;
               col_d   = '0;
               row_d   = '0;
               chr_d   = '0;
            end
         end
         S_ARMED, S_RUN: begin
            if (accept) state_d = last_pix ? S_DRAIN : S_RUN;
         end
         // Empty here means the final entry was popped last edge, so its write is on the port now.
         S_DRAIN: if (fifo_empty) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset) begin
         state_q    <= S_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         chr_q      <= '0;
         org_x_q    <= '0;
         org_y_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         im_a_q     <= '0;
         im_d_q     <= '0;
         im_wen_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         chr_q      <= chr_d;
         org_x_q    <= org_x_d;
         org_y_q    <= org_y_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         im_a_q     <= im_a_d;
         im_d_q     <= im_d_d;
         im_wen_q   <= im_wen_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: FIFO storage is not reset; the reset pointers make stale contents unreachable.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {pix_addr, bus.pix_data};
   end

   assign bus.IM_A     = im_a_q;
   assign bus.IM_D     = im_d_q;
   assign bus.IM_WEN   = im_wen_q;
   assign bus.busy     = (state_q == S_ARMED) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.done     = (state_q == S_DONE);
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_clock_frame_writer.sv
// Directed bench for clock_frame_writer: full frames under several back-pressure patterns,
// abort by reset, and ignored re-arm; writes are captured and compared in stream order.
module tb_clock_frame_writer;
   localparam int FRAME_PIX = 2496;
   localparam int STALL_AT  = 500;
   localparam int ABORT_AT  = 1000;
   localparam int REARM_AT  = 300;

   logic clk;
   logic reset;

   clock_frame_writer_if bus ();

   clock_frame_writer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   logic [39:0] got_q [$];
   logic [39:0] exp_q [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Capture one write per IM_WEN cycle and count done pulses, just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (bus.IM_WEN) got_q.push_back({bus.IM_A, bus.IM_D});
      if (bus.done) done_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   task automatic do_reset();
      bus.frame_arm = 1'b0;
      bus.pix_valid = 1'b0;
      bus.im_ready  = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Drives one frame. mode 0: back-to-back, ready=1; 1: gap then 6-cycle stall at STALL_AT;
   // 2: pixel every other cycle, ready toggling; 3: reset at ABORT_AT; 4: re-arm + origin change.
   task automatic run_frame(input string name, input logic [7:0] ox, input logic [7:0] oy,
                            input int mode, input logic exp_ovf,
                            input int exp_first, input int exp_last);
      int          idx, cyc, ph, col, row, chr, got_base, done_base;
      logic        send, ready;
      logic [23:0] data;
      idx = 0; cyc = 0; ph = 0; col = 0; row = 0; chr = 0;
      exp_q.delete();
      got_base  = got_q.size();
      done_base = done_cnt;

      bus.org_x = ox; bus.org_y = oy; bus.im_ready = 1'b1; bus.pix_valid = 1'b0;
      bus.frame_arm = 1'b1;
      @(negedge clk);
      bus.frame_arm = 1'b0;
      check({name, "_busy_armed"}, 64'(bus.busy), 64'd1);

      while (idx < FRAME_PIX) begin
         send  = 1'b1;
         ready = 1'b1;
         if (mode == 3 && idx == ABORT_AT) begin
            bus.pix_valid = 1'b0;
            reset = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b1;
            check({name, "_rst_wen"},  64'(bus.IM_WEN), 64'd0);
            check({name, "_rst_busy"}, 64'(bus.busy),   64'd0);
            check({name, "_rst_a"},    64'(bus.IM_A),   64'd0);
            repeat (6) @(negedge clk);
            check({name, "_no_done"},  64'(done_cnt - done_base), 64'd0);
            return;
         end
         case (mode)
            1: begin
               if (idx == STALL_AT && ph == 0) begin
                  send = 1'b0;
                  ph   = 1;
               end else if (ph >= 1 && ph <= 6) begin
                  ready = 1'b0;
                  ph++;
               end
            end
            2: begin
               send  = (cyc % 2 == 0);
               ready = (cyc % 2 == 1);
            end
            4: begin
               if (idx == REARM_AT) begin
                  bus.frame_arm = 1'b1;
                  bus.org_x     = ox + 8'd50;
                  bus.org_y     = oy + 8'd9;
               end
            end
            default: ;
         endcase

         data = 24'(idx * 3 + 1);
         if (send && !(mode == 1 && (idx == STALL_AT + 4 || idx == STALL_AT + 5)))
            exp_q.push_back({16'((int'(oy) + row) * 256 + int'(ox) + chr * 13 + col), data});

         bus.pix_valid = send;
         bus.pix_data  = data;
         bus.im_ready  = ready;
         @(negedge clk);
         bus.frame_arm = 1'b0;
         if (send) begin
            idx++;
            col++;
            if (col == 13) begin
               col = 0;
               row++;
               if (row == 24) begin
                  row = 0;
                  chr++;
               end
            end
         end
         cyc++;
      end

      bus.pix_valid = 1'b0;
      bus.im_ready  = 1'b1;
      for (int i = 0; i < 64 && done_cnt == done_base; i++) @(negedge clk);
      repeat (8) @(negedge clk);

      check({name, "_done_once"}, 64'(done_cnt - done_base), 64'd1);
      check({name, "_busy_end"},  64'(bus.busy),     64'd0);
      check({name, "_overflow"},  64'(bus.overflow), 64'(exp_ovf));
      check({name, "_nwrites"},   64'(got_q.size() - got_base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++)
         check($sformatf("%s_wr%0d", name, i), 64'(got_q[got_base + i]), 64'(exp_q[i]));
      if (got_q.size() > got_base) begin
         check({name, "_first_a"}, 64'(got_q[got_base][39:24]), 64'(exp_first));
         check({name, "_last_a"},  64'(got_q[got_q.size() - 1][39:24]), 64'(exp_last));
      end else begin
         check({name, "_any_write"}, 64'(got_q.size()), 64'(got_base + 1));
      end
   endtask

   initial begin
      int base;
      reset = 1'b0;
      bus.frame_arm = 1'b0; bus.org_x = '0; bus.org_y = '0;
      bus.pix_valid = 1'b0; bus.pix_data = '0; bus.im_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_im_a",     64'(bus.IM_A),     64'd0);
      check("rst_im_d",     64'(bus.IM_D),     64'd0);
      check("rst_im_wen",   64'(bus.IM_WEN),   64'd0);
      check("rst_busy",     64'(bus.busy),     64'd0);
      check("rst_done",     64'(bus.done),     64'd0);
      check("rst_overflow", 64'(bus.overflow), 64'd0);

      // Pixels offered while idle must never reach memory.
      reset = 1'b1;
      bus.im_ready = 1'b1;
      base = got_q.size();
      bus.pix_valid = 1'b1; bus.pix_data = 24'hffffff;
      repeat (3) @(negedge clk);
      bus.pix_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_no_write", 64'(got_q.size() - base), 64'd0);
      check("idle_busy",     64'(bus.busy),            64'd0);

      // Origin (10,20): first 20*256+10, pixel 13 at next row, last 43*256+10+91+12.
      base = got_q.size();
      run_frame("b2b", 8'd10, 8'd20, 0, 1'b0, 5130, 11121);
      check("b2b_pix13", 64'(got_q.size() > base + 13 ? got_q[base + 13][39:24] : 16'd0), 64'd5386);

      // Stall with empty FIFO: 4 buffered, pixels STALL_AT+4/+5 dropped. Last = 23*256+103.
      run_frame("stall", 8'd0, 8'd0, 1, 1'b1, 0, 5991);

      do_reset();
      check("ovf_cleared", 64'(bus.overflow), 64'd0);

      // Toggling ready, pixel every other cycle: 100*256+200 .. 123*256+200+103.
      run_frame("toggle", 8'd200, 8'd100, 2, 1'b0, 25800, 31791);

      // Abort by reset, then a fresh frame starting from col=row=chr=0.
      run_frame("abort", 8'd30, 8'd40, 3, 1'b0, 0, 0);
      run_frame("rearm", 8'd100, 8'd200, 0, 1'b0, 51300, 57291);

      // Re-arm mid-frame ignored; origin (5,250) wraps: 64005 first, (273*256+108) mod 65536 last.
      run_frame("ignore", 8'd5, 8'd250, 4, 1'b0, 64005, 4460);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
